key_dispatcher: RTL and testbench
=================================

KEY_DISPATCHER -- requirements
Module: key_dispatcher

Interface
REQ-001 Parameter NUM_CORES, default 4, number of KSA/decrypt cores fed.
REQ-002 Parameter KEY_WIDTH, default 24, secret-key width.
REQ-003 Parameter MAX_KEY, default 24'h3FFFFF, last key searched (inclusive).
REQ-004 Port clk  in  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst  in  1  asynchronous active-high reset.
REQ-006 Port start  in  1  one-cycle pulse that begins a search from key 0.
REQ-007 Port core_key  out  NUM_CORES*KEY_WIDTH  per-core secret key; slice i belongs to core i.
REQ-008 Port core_start  out  NUM_CORES  per-core one-cycle start pulse.
REQ-009 Port core_done  in  NUM_CORES  per-core level; the core has finished checking its key.
REQ-010 Port core_valid  in  NUM_CORES  per-core decrypt-valid flag, qualified by core_done.
REQ-011 Port core_ack  out  NUM_CORES  per-core one-cycle acknowledge of core_done.
REQ-012 Port busy  out  1  high in RUN and DRAIN.
REQ-013 Port found  out  1  high in FOUND.
REQ-014 Port exhausted  out  1  high in EXHAUSTED.
REQ-015 Port found_key  out  KEY_WIDTH  winning key.
REQ-016 Port keys_tried  out  KEY_WIDTH  count of completed key checks.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, FOUND, EXHAUSTED.
REQ-018 start SHALL be accepted only in IDLE, FOUND or EXHAUSTED: next_key, keys_tried and found_key cleared, next state RUN; start is ignored in RUN/DRAIN.
REQ-019 In RUN, at most one dispatch per cycle: the lowest-index idle core while next_key <= MAX_KEY.
REQ-020 Dispatch: core_key[i] <= next_key, core_start[i] pulses for one cycle, core i marked busy, next_key increments by 1; core_key and core_start are registered, visible the cycle after the decision.
REQ-021 A busy core with core_done high SHALL receive core_ack for exactly one cycle in the cycle after done is first seen; the core is marked idle at the same time; core_done asserted while ack is pending is not re-counted.
REQ-022 A core SHALL NOT be re-dispatched earlier than the cycle after its core_ack pulse.
REQ-023 keys_tried increments by 1 per acknowledged done, in RUN and DRAIN.
REQ-024 core_done with core_valid in RUN: found_key <= that core's key, next state DRAIN; if several cores are valid in the same cycle, the lowest index wins.
REQ-025 In DRAIN: no dispatches; outstanding cores are acknowledged normally; further valid results are ignored; when all cores are idle, next state FOUND.
REQ-026 In RUN, when next_key > MAX_KEY and all cores are idle with no valid result, next state EXHAUSTED.
REQ-027 next_key SHALL be KEY_WIDTH+1 bits wide so it cannot wrap at MAX_KEY = 2^KEY_WIDTH-1.
REQ-028 core_done on a core not marked busy SHALL be ignored, with no ack.
REQ-029 Outputs busy, found and exhausted are decoded from registered state, with no combinational path from inputs.

Reset
REQ-030 Asserting rst SHALL asynchronously force IDLE and set every output to 0: core_key, core_start, core_ack, busy, found, exhausted, found_key, keys_tried.
REQ-031 Reset mid-search SHALL abandon all cores; the busy mask clears, and the first start after release begins again at key 0.

Structure
REQ-032 Package ksa_pkg SHALL hold KEY_WIDTH, MAX_KEY defaults and the dispatcher state enum.
REQ-033 One sub-module, first_one_finder (parameterised lowest-set-bit encoder), SHALL be used for idle-core selection and for the valid-result tie-break.

Verification
REQ-034 NUM_CORES=4, MAX_KEY=15, no core ever valid -> keys 0..15 dispatched exactly once, keys_tried=16, exhausted=1, found=0.
REQ-035 NUM_CORES=4, core 2 valid on key 6 -> found_key=6, remaining busy cores acked in DRAIN, then found=1 and no key >9 dispatched.
REQ-036 Cores 1 and 3 valid in the same cycle (keys 5, 7) -> found_key=5.
REQ-037 start pulsed during RUN -> ignored; next_key continues with no restart.
REQ-038 rst asserted in RUN with 4 cores busy -> all outputs 0 immediately; a following start dispatches key 0 to core 0.
REQ-039 MAX_KEY=24'hFFFFFF, search primed near the top, no valid -> last dispatched key is FFFFFF, then EXHAUSTED with no wrap to 0.

Source files
------------

// File: rtl/ksa_pkg.sv
// Shared definitions for the key-search slice: default key-space limits and
// the dispatcher state encoding.
package ksa_pkg;

   localparam int          DEFAULT_KEY_WIDTH = 24;
   localparam logic [23:0] DEFAULT_MAX_KEY   = 24'h3FFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_FOUND,
      ST_EXHAUSTED
   } disp_state_e;

endpackage

// File: rtl/first_one_finder.sv
// Lowest-set-bit encoder. It reports the index of the least significant request
// bit and whether any bit was set.
module first_one_finder #(
   parameter  int WIDTH = 4,
   localparam int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] req_i,
   output logic [IDXW-1:0]  idx_o,
   output logic             any_o
);

   // Scan from the top down so that the last hit written is the lowest index.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o = IDXW'(i);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_dispatcher.sv
// Hands out consecutive secret keys to a pool of KSA/decrypt cores, collects
// their done/valid results, and stops on the first valid key or at MAX_KEY.
module key_dispatcher
   import ksa_pkg::*;
#(
   parameter int                   NUM_CORES = 4,
   parameter int                   KEY_WIDTH = DEFAULT_KEY_WIDTH,
   parameter logic [KEY_WIDTH-1:0] MAX_KEY   = KEY_WIDTH'(DEFAULT_MAX_KEY)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
   output logic [NUM_CORES-1:0]           core_start,
   input  logic [NUM_CORES-1:0]           core_done,
   input  logic [NUM_CORES-1:0]           core_valid,
   output logic [NUM_CORES-1:0]           core_ack,
   output logic                           busy,
   output logic                           found,
   output logic                           exhausted,
   output logic [KEY_WIDTH-1:0]           found_key,
   output logic [KEY_WIDTH-1:0]           keys_tried
);

   localparam int IDXW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int NKW  = KEY_WIDTH + 1;

   // The extra top bit lets next_key step past an all-ones MAX_KEY without wrapping.
   localparam logic [NKW-1:0] LAST_KEY = {1'b0, MAX_KEY};

   disp_state_e state_q;
   disp_state_e state_d;

   logic [NKW-1:0]       nextKey_q;
   logic [NKW-1:0]       nextKey_d;
   logic [NUM_CORES-1:0] busyMask_q;
   logic [NUM_CORES-1:0] busyMask_d;
   logic [NUM_CORES-1:0] ack_q;
   logic [NUM_CORES-1:0] ack_d;
   logic [NUM_CORES-1:0] coreStart_q;
   logic [NUM_CORES-1:0] coreStart_d;
   logic [KEY_WIDTH-1:0] coreKey_q [NUM_CORES];
   logic [KEY_WIDTH-1:0] coreKey_d [NUM_CORES];
   logic [KEY_WIDTH-1:0] foundKey_q;
   logic [KEY_WIDTH-1:0] foundKey_d;
   logic [KEY_WIDTH-1:0] keysTried_q;
   logic [KEY_WIDTH-1:0] keysTried_d;

   logic [NUM_CORES-1:0] doneSeen;
   logic [NUM_CORES-1:0] validHit;
   logic [NUM_CORES-1:0] idleMask;
   logic [IDXW-1:0]      idleIdx;
   logic [IDXW-1:0]      validIdx;
   logic                 idleAny;
   logic                 validAny;
   logic                 keysLeft;
   logic                 startAccept;
   logic                 active;

   // Clearing the busy bit together with the ack means a done still held
   // during the ack cycle is not counted twice.
   assign doneSeen    = busyMask_q & core_done;
   assign validHit    = doneSeen & core_valid;
   assign idleMask    = ~busyMask_q & ~ack_q;
   assign keysLeft    = (nextKey_q <= LAST_KEY);
   assign startAccept = start && (state_q inside {ST_IDLE, ST_FOUND, ST_EXHAUSTED});
   assign active      = (state_q == ST_RUN) || (state_q == ST_DRAIN);

   first_one_finder #(
      .WIDTH (NUM_CORES)
   ) u_idleSel (
      .req_i (idleMask),
      .idx_o (idleIdx),
      .any_o (idleAny)
   );

   first_one_finder #(
      .WIDTH (NUM_CORES)
   ) u_validSel (
      .req_i (validHit),
      .idx_o (validIdx),
      .any_o (validAny)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
            if (start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (validAny) begin
               state_d = ST_DRAIN;
            end else if (!keysLeft && (busyMask_q == '0)) begin
               state_d = ST_EXHAUSTED;
            end
         end
         ST_DRAIN: begin
            if (busyMask_q == '0) begin
               state_d = ST_FOUND;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      found     = (state_q == ST_FOUND);
      exhausted = (state_q == ST_EXHAUSTED);
   end

   // The dispatch is suppressed in the cycle a winner is seen, so no new key
   // goes out once the search is known to be over.
   always_comb begin
      nextKey_d   = nextKey_q;
      busyMask_d  = busyMask_q;
      ack_d       = '0;
      coreStart_d = '0;
      coreKey_d   = coreKey_q;
      foundKey_d  = foundKey_q;
      keysTried_d = keysTried_q;

      if (startAccept) begin
         nextKey_d   = '0;
         keysTried_d = '0;
         foundKey_d  = '0;
      end

      if (active) begin
         ack_d      = doneSeen;
         busyMask_d = busyMask_q & ~doneSeen;
         for (int i = 0; i < NUM_CORES; i++) begin
            if (doneSeen[i]) begin
               keysTried_d = keysTried_d + KEY_WIDTH'(1);
            end
         end
      end

      if ((state_q == ST_RUN) && validAny) begin
         foundKey_d = coreKey_q[validIdx];
      end

      if ((state_q == ST_RUN) && !validAny && keysLeft && idleAny) begin
         coreStart_d[idleIdx] = 1'b1;
         coreKey_d[idleIdx]   = nextKey_q[KEY_WIDTH-1:0];
         busyMask_d[idleIdx]  = 1'b1;
         nextKey_d            = nextKey_q + NKW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nextKey_q   <= '0;
         busyMask_q  <= '0;
         ack_q       <= '0;
         coreStart_q <= '0;
         foundKey_q  <= '0;
         keysTried_q <= '0;
         for (int i = 0; i < NUM_CORES; i++) begin
            coreKey_q[i] <= '0;
         end
      end else begin
         nextKey_q   <= nextKey_d;
         busyMask_q  <= busyMask_d;
         ack_q       <= ack_d;
         coreStart_q <= coreStart_d;
         foundKey_q  <= foundKey_d;
         keysTried_q <= keysTried_d;
         for (int i = 0; i < NUM_CORES; i++) begin
            coreKey_q[i] <= coreKey_d[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_keyOut
      assign core_key[g*KEY_WIDTH +: KEY_WIDTH] = coreKey_q[g];
   end

   assign core_start = coreStart_q;
   assign core_ack   = ack_q;
   assign found_key  = foundKey_q;
   assign keys_tried = keysTried_q;

endmodule

// File: tb/tb_key_dispatcher.sv
// Bench for key_dispatcher: a behavioural core pool answers dispatched keys and
// a scoreboard holds the key order each search is expected to produce.
module tb_key_dispatcher;

   localparam int NC     = 4;
   localparam int KW     = 24;
   localparam int KW2    = 4;
   localparam int BUDGET = 600;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic start1 = 1'b0;
   logic start2 = 1'b0;

   logic [NC-1:0]    coreDone  = '0;
   logic [NC-1:0]    coreValid = '0;

   logic [NC*KW-1:0] coreKey1;
   logic [NC-1:0]    coreStart1;
   logic [NC-1:0]    coreAck1;
   logic             busy1;
   logic             found1;
   logic             exhausted1;
   logic [KW-1:0]    foundKey1;
   logic [KW-1:0]    keysTried1;

   logic [NC*KW2-1:0] coreKey2;
   logic [NC-1:0]     coreStart2;
   logic [NC-1:0]     coreAck2;
   logic              busy2;
   logic              found2;
   logic              exhausted2;
   logic [KW2-1:0]    foundKey2;
   logic [KW2-1:0]    keysTried2;

   int checks = 0;
   int passes = 0;

   // Core pool model and scoreboard state
   bit            useTop = 1'b0;
   bit            holdMode;
   int            lat;
   int            validA;
   int            validB;
   int            tieExpKey;
   int            cnt   [NC];
   int            keyM  [NC];
   bit            armed [NC];
   bit            ready [NC];
   int            multiDisp;
   int            ackLong;
   logic [NC-1:0] prevAck;
   int            expQ[$];
   int            obsKeyQ[$];
   int            obsCoreQ[$];

   key_dispatcher #(
      .NUM_CORES (NC),
      .KEY_WIDTH (KW),
      .MAX_KEY   (24'd15)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start1),
      .core_key   (coreKey1),
      .core_start (coreStart1),
      .core_done  (coreDone),
      .core_valid (coreValid),
      .core_ack   (coreAck1),
      .busy       (busy1),
      .found      (found1),
      .exhausted  (exhausted1),
      .found_key  (foundKey1),
      .keys_tried (keysTried1)
   );

   key_dispatcher #(
      .NUM_CORES (NC),
      .KEY_WIDTH (KW2),
      .MAX_KEY   (4'hF)
   ) dutTop (
      .clk        (clk),
      .rst        (rst),
      .start      (start2),
      .core_key   (coreKey2),
      .core_start (coreStart2),
      .core_done  (coreDone),
      .core_valid (coreValid),
      .core_ack   (coreAck2),
      .busy       (busy2),
      .found      (found2),
      .exhausted  (exhausted2),
      .found_key  (foundKey2),
      .keys_tried (keysTried2)
   );

   always #5 clk = ~clk;

   function automatic int obsKey(int i);
      if (useTop) return int'(coreKey2[i*KW2 +: KW2]);
      return int'(coreKey1[i*KW +: KW]);
   endfunction

   function automatic bit isValid(int k);
      return (k == validA) || (k == validB);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < NC; i++) begin
         cnt[i]   = 0;
         keyM[i]  = 0;
         armed[i] = 1'b0;
         ready[i] = 1'b0;
      end
      coreDone  = '0;
      coreValid = '0;
      holdMode  = 1'b0;
      lat       = 2;
      validA    = -1;
      validB    = -1;
      tieExpKey = -1;
      multiDisp = 0;
      ackLong   = 0;
      prevAck   = '0;
      expQ.delete();
      obsKeyQ.delete();
      obsCoreQ.delete();
   endtask

   // Each core raises done lat cycles after its start and drops it on ack;
   // in hold mode the valid keys wait for each other and finish together.
   task automatic coreStep();
      logic [NC-1:0] st;
      logic [NC-1:0] ak;
      int            nr;
      st = useTop ? coreStart2 : coreStart1;
      ak = useTop ? coreAck2 : coreAck1;
      for (int i = 0; i < NC; i++) begin
         if (ak[i]) begin
            coreDone[i]  = 1'b0;
            coreValid[i] = 1'b0;
         end
         if (st[i]) begin
            keyM[i]  = obsKey(i);
            cnt[i]   = lat;
            armed[i] = 1'b1;
            ready[i] = 1'b0;
         end else if (armed[i] && !ready[i]) begin
            cnt[i] = cnt[i] - 1;
            if (cnt[i] <= 0) begin
               if (holdMode && isValid(keyM[i])) begin
                  ready[i] = 1'b1;
               end else begin
                  coreDone[i]  = 1'b1;
                  coreValid[i] = isValid(keyM[i]);
                  armed[i]     = 1'b0;
               end
            end
         end
      end
      if (holdMode) begin
         nr = 0;
         for (int i = 0; i < NC; i++) if (ready[i]) nr++;
         if (nr >= 2) begin
            for (int i = NC - 1; i >= 0; i--) begin
               if (ready[i]) begin
                  coreDone[i]  = 1'b1;
                  coreValid[i] = 1'b1;
                  armed[i]     = 1'b0;
                  ready[i]     = 1'b0;
                  tieExpKey    = keyM[i];
               end
            end
         end
      end
   endtask

   task automatic tick();
      logic [NC-1:0] st;
      logic [NC-1:0] ak;
      int            n;
      @(negedge clk);
      st = useTop ? coreStart2 : coreStart1;
      ak = useTop ? coreAck2 : coreAck1;
      n  = 0;
      for (int i = 0; i < NC; i++) begin
         if (st[i]) begin
            obsKeyQ.push_back(obsKey(i));
            obsCoreQ.push_back(i);
            n++;
         end
      end
      if (n > 1) multiDisp++;
      if (|(ak & prevAck)) ackLong++;
      prevAck = ak;
      coreStep();
   endtask

   task automatic pushKeys(int last);
      for (int k = 0; k <= last; k++) expQ.push_back(k);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (coreKey1 !== '0) $display("[TB] FAIL reset_core_key: got %0h required 0", coreKey1); else passes++;
      checks++; if ({coreStart1, coreAck1} !== '0) $display("[TB] FAIL reset_start_ack: got %0h required 0", {coreStart1, coreAck1}); else passes++;
      checks++; if ({busy1, found1, exhausted1} !== 3'b000) $display("[TB] FAIL reset_flags: got %0b required 000", {busy1, found1, exhausted1}); else passes++;
      checks++; if ({foundKey1, keysTried1} !== '0) $display("[TB] FAIL reset_counts: got %0h required 0", {foundKey1, keysTried1}); else passes++;
      checks++; if ({busy2, found2, exhausted2, foundKey2, keysTried2, coreKey2} !== '0) $display("[TB] FAIL reset_top_dut: got nonzero outputs"); else passes++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_spurious_done();
      modelReset();
      coreDone  = 4'hF;
      coreValid = 4'hF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (coreAck1 !== 4'h0) $display("[TB] FAIL spurious_ack: got %0b required 0000", coreAck1); else passes++;
      end
      checks++; if (keysTried1 !== '0) $display("[TB] FAIL spurious_tried: got %0d required 0", keysTried1); else passes++;
      checks++; if ({busy1, found1} !== 2'b00) $display("[TB] FAIL spurious_state: got %0b required 00", {busy1, found1}); else passes++;
      coreDone  = '0;
      coreValid = '0;
      @(negedge clk);
   endtask

   task automatic test_exhaust();
      int got;
      int exp;
      modelReset();
      pushKeys(15);
      start1 = 1'b1; tick(); start1 = 1'b0;
      for (int c = 0; c < BUDGET && exhausted1 !== 1'b1; c++) tick();
      checks++; if (exhausted1 !== 1'b1) $display("[TB] FAIL exhaust_flag: got %0b required 1", exhausted1); else passes++;
      checks++; if (obsKeyQ.size() != 16) $display("[TB] FAIL exhaust_count: got %0d required 16", obsKeyQ.size()); else passes++;
      while (obsKeyQ.size() > 0 && expQ.size() > 0) begin
         got = obsKeyQ.pop_front();
         exp = expQ.pop_front();
         checks++; if (got != exp) $display("[TB] FAIL exhaust_key: got %0d required %0d", got, exp); else passes++;
      end
      checks++; if (keysTried1 !== 24'd16) $display("[TB] FAIL exhaust_tried: got %0d required 16", keysTried1); else passes++;
      checks++; if ({found1, busy1} !== 2'b00) $display("[TB] FAIL exhaust_found_busy: got %0b required 00", {found1, busy1}); else passes++;
      checks++; if (multiDisp != 0) $display("[TB] FAIL exhaust_one_dispatch: got %0d multi-dispatch cycles required 0", multiDisp); else passes++;
      checks++; if (ackLong != 0) $display("[TB] FAIL exhaust_ack_pulse: got %0d long acks required 0", ackLong); else passes++;
   endtask

   task automatic test_found();
      int got;
      int exp;
      int nDisp;
      int maxKey;
      modelReset();
      validA = 6;
      pushKeys(15);
      start1 = 1'b1; tick(); start1 = 1'b0;
      for (int c = 0; c < BUDGET && found1 !== 1'b1; c++) tick();
      repeat (3) tick();
      nDisp  = obsKeyQ.size();
      maxKey = -1;
      checks++; if (found1 !== 1'b1) $display("[TB] FAIL found_flag: got %0b required 1", found1); else passes++;
      checks++; if (foundKey1 !== 24'd6) $display("[TB] FAIL found_key: got %0d required 6", foundKey1); else passes++;
      while (obsKeyQ.size() > 0 && expQ.size() > 0) begin
         got = obsKeyQ.pop_front();
         exp = expQ.pop_front();
         if (got > maxKey) maxKey = got;
         checks++; if (got != exp) $display("[TB] FAIL found_seq: got %0d required %0d", got, exp); else passes++;
      end
      checks++; if (maxKey > 9) $display("[TB] FAIL found_max_key: got %0d required at most 9", maxKey); else passes++;
      checks++; if (int'(keysTried1) != nDisp) $display("[TB] FAIL found_drain_acks: got %0d required %0d", keysTried1, nDisp); else passes++;
      checks++; if ({busy1, exhausted1} !== 2'b00) $display("[TB] FAIL found_state: got %0b required 00", {busy1, exhausted1}); else passes++;
   endtask

   task automatic test_tie();
      int got;
      int exp;
      modelReset();
      holdMode = 1'b1;
      validA   = 5;
      validB   = 7;
      pushKeys(15);
      start1 = 1'b1; tick(); start1 = 1'b0;
      for (int c = 0; c < BUDGET && found1 !== 1'b1; c++) tick();
      checks++; if (found1 !== 1'b1) $display("[TB] FAIL tie_flag: got %0b required 1", found1); else passes++;
      checks++; if (int'(foundKey1) != tieExpKey) $display("[TB] FAIL tie_key: got %0d required %0d", foundKey1, tieExpKey); else passes++;
      while (obsKeyQ.size() > 0 && expQ.size() > 0) begin
         got = obsKeyQ.pop_front();
         exp = expQ.pop_front();
         checks++; if (got != exp) $display("[TB] FAIL tie_seq: got %0d required %0d", got, exp); else passes++;
      end
   endtask

   task automatic test_start_ignored();
      int got;
      int exp;
      modelReset();
      pushKeys(15);
      start1 = 1'b1; tick(); start1 = 1'b0;
      repeat (8) tick();
      start1 = 1'b1; tick(); start1 = 1'b0;
      for (int c = 0; c < BUDGET && exhausted1 !== 1'b1; c++) tick();
      checks++; if (exhausted1 !== 1'b1) $display("[TB] FAIL restart_exhaust: got %0b required 1", exhausted1); else passes++;
      checks++; if (obsKeyQ.size() != 16) $display("[TB] FAIL restart_count: got %0d required 16", obsKeyQ.size()); else passes++;
      while (obsKeyQ.size() > 0 && expQ.size() > 0) begin
         got = obsKeyQ.pop_front();
         exp = expQ.pop_front();
         checks++; if (got != exp) $display("[TB] FAIL restart_seq: got %0d required %0d", got, exp); else passes++;
      end
      checks++; if (keysTried1 !== 24'd16) $display("[TB] FAIL restart_tried: got %0d required 16", keysTried1); else passes++;
   endtask

   task automatic test_reset_midrun();
      modelReset();
      lat = 10;
      start1 = 1'b1; tick(); start1 = 1'b0;
      for (int c = 0; c < 20 && obsKeyQ.size() < 4; c++) tick();
      checks++; if (obsKeyQ.size() != 4) $display("[TB] FAIL midrun_dispatched: got %0d required 4", obsKeyQ.size()); else passes++;
      #2 rst = 1'b1;
      #1;
      checks++; if (coreKey1 !== '0) $display("[TB] FAIL midrun_core_key: got %0h required 0", coreKey1); else passes++;
      checks++; if ({coreStart1, coreAck1, busy1, found1, exhausted1} !== '0) $display("[TB] FAIL midrun_ctrl: got %0h required 0", {coreStart1, coreAck1, busy1, found1, exhausted1}); else passes++;
      checks++; if ({foundKey1, keysTried1} !== '0) $display("[TB] FAIL midrun_counts: got %0h required 0", {foundKey1, keysTried1}); else passes++;
      @(negedge clk);
      modelReset();
      rst = 1'b0;
      @(negedge clk);
      start1 = 1'b1; tick(); start1 = 1'b0;
      for (int c = 0; c < 10 && obsKeyQ.size() < 1; c++) tick();
      checks++; if (obsKeyQ.size() < 1) $display("[TB] FAIL midrun_restart_timeout: got 0 dispatches required 1"); else passes++;
      if (obsKeyQ.size() > 0) begin
         checks++; if (obsCoreQ[0] != 0) $display("[TB] FAIL midrun_restart_core: got %0d required 0", obsCoreQ[0]); else passes++;
         checks++; if (obsKeyQ[0] != 0) $display("[TB] FAIL midrun_restart_key: got %0d required 0", obsKeyQ[0]); else passes++;
      end
      rst = 1'b1;
      @(negedge clk);
      modelReset();
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_top_boundary();
      int got;
      int exp;
      int lastKey;
      useTop = 1'b1;
      modelReset();
      pushKeys(15);
      start2 = 1'b1; tick(); start2 = 1'b0;
      for (int c = 0; c < BUDGET && exhausted2 !== 1'b1; c++) tick();
      repeat (6) tick();
      checks++; if (exhausted2 !== 1'b1) $display("[TB] FAIL top_exhaust: got %0b required 1", exhausted2); else passes++;
      checks++; if ({found2, busy2} !== 2'b00) $display("[TB] FAIL top_state: got %0b required 00", {found2, busy2}); else passes++;
      checks++; if (obsKeyQ.size() != 16) $display("[TB] FAIL top_count: got %0d required 16", obsKeyQ.size()); else passes++;
      lastKey = (obsKeyQ.size() > 0) ? obsKeyQ[obsKeyQ.size()-1] : -1;
      checks++; if (lastKey != 15) $display("[TB] FAIL top_last_key: got %0d required 15", lastKey); else passes++;
      while (obsKeyQ.size() > 0 && expQ.size() > 0) begin
         got = obsKeyQ.pop_front();
         exp = expQ.pop_front();
         checks++; if (got != exp) $display("[TB] FAIL top_seq: got %0d required %0d", got, exp); else passes++;
      end
      useTop = 1'b0;
   endtask

   initial begin
      $display("[TB] key_dispatcher bench starting");
      test_reset();
      test_spurious_done();
      test_exhaust();
      test_found();
      test_tie();
      test_start_ignored();
      test_reset_midrun();
      test_top_boundary();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
